// File: rtl/alu_seq_if.sv
// alu_seq_if -- requester/response bundle of the ALU sequencer.
//
// Valid/ready rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. A master holds its payload stable
// while valid is high and not yet accepted; ready may depend combinationally
// on valid, but valid never depends on ready.
//
// Signals:
//   req_valid  [1:0]        per-requester request valid (bit n = requester n)
//   req_ready  [1:0]        per-requester accept, at most one bit high
//   req_op     [2*OPW-1:0]  opcodes, requester n at [n*OPW +: OPW]
//   req_a/b    [2*WIDTH-1:0] operands, packed like req_op
//   rsp_valid/rsp_ready     response channel handshake
//   rsp_id                  requester index of the response
//   rsp_data/rsp_data2      primary result / SWAP second result (else 0)
// Modports: master = requester side, slave = sequencer side.
interface alu_seq_if #(
  parameter int WIDTH = 20,
  parameter int OPW   = 5
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*OPW-1:0]   req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic [WIDTH-1:0]   rsp_data2;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_data2
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_data2
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- round-robin sequencer in front of a combinational ALU.
//
// Two requesters share the ALU. In IDLE one requester is granted, its
// op/operands are latched, driven to the ALU for exactly one ISSUE cycle, and
// the ALU result/flags are captured into a tagged response held in RESP until
// accepted. The block owns the {C,S,Z} status register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         requester/response channels (see alu_seq_if)
//   alu_op/a/b/cin      ALU drive; op/a/b are zero outside ISSUE
//   alu_res/res2/flags  ALU results, flags = {carry,sign,zero}
//   status              status register {C,S,Z}
//   busy                high whenever the FSM is not in IDLE
//   state_dbg           current FSM state encoding
//   trap, trap_clr      only with ALU_SEQ_TRAP_EN
//
// Optional feature macro: ALU_SEQ_TRAP_EN. When defined, an illegal opcode
// (23..31) skips ISSUE and parks in TRAP until trap_clr. When undefined,
// illegal opcodes act as NOP with rsp_data = 0.
module alu_seq_ctrl #(
  parameter int WIDTH = 20,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_if.slave         bus,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] alu_res2,
  input  logic [2:0]       alu_flags,
  output logic [2:0]       status,
  output logic             busy,
  output logic [1:0]       state_dbg
`ifdef ALU_SEQ_TRAP_EN
  ,
  output logic             trap,
  input  logic             trap_clr
`endif
);

  localparam logic [OPW-1:0] OP_NOT  = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SWAP = OPW'(9);
  localparam logic [OPW-1:0] OP_INC  = OPW'(10);
  localparam logic [OPW-1:0] OP_SBC  = OPW'(15);
  localparam logic [OPW-1:0] OP_EQ   = OPW'(16);
  localparam logic [OPW-1:0] OP_LE   = OPW'(20);
  localparam logic [OPW-1:0] OP_LDSR = OPW'(21);
  localparam logic [OPW-1:0] OP_XSR  = OPW'(22);

`ifdef ALU_SEQ_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2, TRAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             last_id;   // requester granted last; reset to 1 so req0 wins a tie
  logic             win;
  logic             hs;
  logic [OPW-1:0]   sel_op;
  logic             legal_q;
  logic [2:0]       flag_mask; // which of {C,S,Z} the captured op updates
  logic [2:0]       status_nxt;
  logic [WIDTH-1:0] res_sel;

  // Arbitration: a lone valid wins; on a tie the requester not granted last wins.
  always_comb begin
    win = 1'b0;
    if (&bus.req_valid) win = ~last_id;
    else                win = bus.req_valid[1];
    bus.req_ready = 2'b00;
    // Gating with rst_n keeps ready low while reset is held, not just after.
    if (state == IDLE && rst_n && |bus.req_valid)
      bus.req_ready = win ? 2'b10 : 2'b01;
    hs     = |(bus.req_valid & bus.req_ready);
    sel_op = win ? bus.req_op[2*OPW-1:OPW] : bus.req_op[OPW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
`ifdef ALU_SEQ_TRAP_EN
          if (sel_op > OP_XSR) state_nxt = TRAP;
          else                 state_nxt = ISSUE;
`else
          state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
`ifdef ALU_SEQ_TRAP_EN
      TRAP:  if (trap_clr) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Result selection and status merge for the op currently in ISSUE.
  always_comb begin
    legal_q   = (op_q <= OP_XSR);
    flag_mask = 3'b000;
    if (op_q >= OP_NOT && op_q <= OP_XOR)      flag_mask = 3'b001;
    else if (op_q == OP_SHR || op_q == OP_SHL) flag_mask = 3'b101;
    else if (op_q >= OP_INC && op_q <= OP_SBC) flag_mask = 3'b111;
    else if (op_q >= OP_EQ && op_q <= OP_LE)   flag_mask = 3'b011;
    status_nxt = (status & ~flag_mask) | (alu_flags & flag_mask);
    res_sel    = legal_q ? alu_res : '0;
    if (op_q == OP_LDSR) begin
      status_nxt = a_q[2:0];
      res_sel    = {{(WIDTH-3){1'b0}}, a_q[2:0]};
    end else if (op_q == OP_XSR) begin
      status_nxt = status ^ a_q[2:0];
      res_sel    = {{(WIDTH-3){1'b0}}, status ^ a_q[2:0]};
    end
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (state == ISSUE) begin
      alu_op = legal_q ? op_q : '0;
      alu_a  = a_q;
      alu_b  = b_q;
    end
  end

  assign alu_cin       = status[2];
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign bus.rsp_valid = (state == RESP);
`ifdef ALU_SEQ_TRAP_EN
  assign trap = (state == TRAP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 1'b0;
      last_id       <= 1'b1;
      status        <= 3'b000;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_data2 <= '0;
    end else begin
      if (state == IDLE && hs) begin
        op_q <= sel_op;
        a_q  <= win ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_q  <= win ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        id_q <= win;
      end
      if (state == ISSUE) begin
        status        <= status_nxt;
        bus.rsp_id    <= id_q;
        bus.rsp_data  <= res_sel;
        bus.rsp_data2 <= (op_q == OP_SWAP) ? alu_res2 : '0;
      end
      if (state == RESP && bus.rsp_ready) last_id <= bus.rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_res, alu_res2;
  logic         alu_cin;
  logic [2:0]   alu_flags, status;
  logic         busy;
  logic [1:0]   state_dbg;
`ifdef ALU_SEQ_TRAP_EN
  logic         trap;
  logic         trap_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  alu_seq_if #(.WIDTH(W), .OPW(5)) bus ();

  alu_seq_ctrl #(.WIDTH(W), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_res2(alu_res2), .alu_flags(alu_flags),
    .status(status), .busy(busy), .state_dbg(state_dbg)
`ifdef ALU_SEQ_TRAP_EN
    , .trap(trap), .trap_clr(trap_clr)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Reference ALU: stands in for the real combinational ALU.
  always_comb begin
    logic [W:0] wide;
    wide      = '0;
    alu_res2  = '0;
    case (alu_op)
      5'd1:  wide = {1'b0, ~alu_a};
      5'd2:  wide = {1'b0, alu_a & alu_b};
      5'd3:  wide = {1'b0, alu_a | alu_b};
      5'd4:  wide = {1'b0, alu_a ^ alu_b};
      5'd9:  begin wide = {1'b0, alu_b}; alu_res2 = alu_a; end
      5'd10: wide = {1'b0, alu_a} + 21'd1;
      5'd12: wide = {1'b0, alu_a} + {1'b0, alu_b};
      5'd13: wide = {1'b0, alu_a} + {1'b0, alu_b} + {20'd0, alu_cin};
      5'd14: wide = {1'b0, alu_a} - {1'b0, alu_b};
      default: wide = '0;
    endcase
    alu_res   = wide[W-1:0];
    alu_flags = {wide[W], wide[W-1], (wide[W-1:0] == '0)};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [4:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    if (id) begin
      bus.req_op[9:5] = op; bus.req_a[39:20] = a; bus.req_b[39:20] = b;
    end else begin
      bus.req_op[4:0] = op; bus.req_a[19:0] = a; bus.req_b[19:0] = b;
    end
    bus.req_valid[id] = 1'b1;
  endtask

  // Wait (bounded) for the grant to requester id; the handshake happens at the next posedge.
  task automatic wait_grant(input logic id);
    int n;
    n = 0;
    #1;
    while (!bus.req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant", {62'd0, bus.req_ready}, id ? 64'd2 : 64'd1);
    @(posedge clk);
  endtask

  // Full single-requester transaction. Expected rsp_data is queued by the caller.
  task automatic run_op(input logic id, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall, input logic [4:0] exp_alu_op,
                        input logic exp_cin, input logic [W-1:0] exp_d2,
                        input logic [2:0] exp_status);
    logic [W-1:0] exp_d;
    @(negedge clk);
    drive_req(id, op, a, b);
    wait_grant(id);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    check("issue_op", alu_op, exp_alu_op);
    if (exp_alu_op != 0) check("issue_a", alu_a, a);
    check("issue_cin", alu_cin, exp_cin);
    check("issue_rsp_valid", bus.rsp_valid, 0);
    exp_d = exp_q.pop_front();
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      bus.req_valid[~id] = 1'b1;
      #1;
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_ready", bus.req_ready, 2'b00);
      check("stall_alu_op", alu_op, 0);
      check("stall_data", bus.rsp_data, exp_d);
      check("stall_data2", bus.rsp_data2, exp_d2);
      check("stall_status", status, exp_status);
      bus.req_valid = 2'b00;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_id", bus.rsp_id, id);
    check("rsp_data", bus.rsp_data, exp_d);
    check("rsp_data2", bus.rsp_data2, exp_d2);
    check("status", status, exp_status);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("idle_busy", busy, 0);
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    // 1: reset with both requests pending
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_status", status, 3'b000);
    check("rst_alu_op", alu_op, 0);
    check("rst_busy", busy, 0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: ADD overflow -> 0, C=1 Z=1
    exp_q.push_back(20'h00000);
    run_op(1'b0, 5'd12, 20'hFFFFF, 20'h00001, 0, 5'd12, 1'b0, 20'h0, 3'b101);

    // 3: ADC uses C as carry-in: 1+1+1 = 3, flags clear
    exp_q.push_back(20'h00003);
    run_op(1'b1, 5'd13, 20'h00001, 20'h00001, 0, 5'd13, 1'b1, 20'h0, 3'b000);

    // 4: both requesting -> alternate 0,1,0,1
    @(negedge clk);
    drive_req(1'b0, 5'd2, 20'hF0F0F, 20'hFF00F);
    drive_req(1'b1, 5'd3, 20'h0000F, 20'h000F0);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk); #1;
      check("rr_issue_ready", bus.req_ready, 2'b00);
      @(negedge clk); #1;
      check("rr_rsp_id", bus.rsp_id, k % 2);
      check("rr_rsp_data", bus.rsp_data, (k % 2) ? 20'h000FF : 20'hF000F);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    check("rr_status", status, 3'b000);

    // 5: SWAP with a 5-cycle response stall
    exp_q.push_back(20'hABCDE);
    run_op(1'b0, 5'd9, 20'h12345, 20'hABCDE, 5, 5'd9, 1'b0, 20'h12345, 3'b000);

    // LDSR / XSR set up a non-zero status
    exp_q.push_back(20'h00005);
    run_op(1'b1, 5'd21, 20'h00005, 20'h0, 0, 5'd21, 1'b0, 20'h0, 3'b101);

    // 6: illegal opcode 25
`ifdef ALU_SEQ_TRAP_EN
    @(negedge clk);
    drive_req(1'b0, 5'd25, 20'h11111, 20'h0);
    wait_grant(1'b0);
    @(negedge clk);
    #1;
    check("trap_set", trap, 1);
    check("trap_rsp_valid", bus.rsp_valid, 0);
    check("trap_ready", bus.req_ready, 2'b00);
    bus.req_valid = 2'b00;
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    #1;
    check("trap_clr", trap, 0);
    check("trap_busy", busy, 0);
    check("trap_status", status, 3'b101);
`else
    exp_q.push_back(20'h00000);
    run_op(1'b0, 5'd25, 20'h11111, 20'h22222, 0, 5'd0, 1'b1, 20'h0, 3'b101);
`endif

    // XSR: 101 ^ 111 = 010
    exp_q.push_back(20'h00002);
    run_op(1'b1, 5'd22, 20'h00007, 20'h0, 0, 5'd22, 1'b1, 20'h0, 3'b010);

    // Reset during ISSUE drops the op and clears status
    @(negedge clk);
    drive_req(1'b0, 5'd12, 20'h00003, 20'h00004);
    wait_grant(1'b0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_status", status, 3'b000);
    check("midrst_busy", busy, 0);
    check("midrst_alu_op", alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("midrst_no_rsp", bus.rsp_valid, 0);
    end
    bus.rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
